// File: rtl/icache_fetch_ctrl.sv
// icache_fetch_ctrl: splits FTQ fetch blocks into one or two icache line
// requests (one outstanding), then aligns the returned line(s) into a single
// byte-aligned fetch packet for predecode. A squash abandons the block and
// swallows the one icache response that may still be on its way.
//
// Handshakes: a transfer happens on a rising clk edge when valid and ready are
// both high; a valid, once raised, holds its payload stable until that edge
// (or until a squash), and valid never depends on ready.
module icache_fetch_ctrl #(
  parameter int XLEN       = 64,
  parameter int LINE_BYTES = 64,
  parameter int FTQ_IDX_W  = 5,
  parameter int MAX_BLOCK  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_squash_vld,
  input  logic                    i_fetch_req,
  output logic                    o_fetch_rdy,
  input  logic [FTQ_IDX_W-1:0]    i_fetch_ftqIdx,
  input  logic [XLEN-1:0]         i_fetch_startAddr,
  input  logic [6:0]              i_fetch_size,
  output logic                    o_line_req,
  output logic [XLEN-1:0]         o_line_addr,
  input  logic                    i_line_rdy,
  input  logic                    i_line_resp_vld,
  input  logic [LINE_BYTES*8-1:0] i_line_data,
  output logic                    o_pkt_vld,
  input  logic                    i_pkt_rdy,
  output logic [FTQ_IDX_W-1:0]    o_pkt_ftqIdx,
  output logic [XLEN-1:0]         o_pkt_startAddr,
  output logic [6:0]              o_pkt_size,
  output logic [MAX_BLOCK*8-1:0]  o_pkt_data,
  output logic [2:0]              o_dbg_state,
  output logic                    o_dbg_drop_pend
);

  localparam int OFFW = $clog2(LINE_BYTES);
  localparam int LW   = LINE_BYTES * 8;
  localparam int PW   = MAX_BLOCK * 8;
  // off + size needs one bit beyond the line offset plus headroom for size
  localparam int SUMW = (OFFW + 2 > 8) ? OFFW + 2 : 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                 state_q;
  logic                   drop_pend_q;
  logic [FTQ_IDX_W-1:0]   ftq_idx_q;
  logic [XLEN-1:0]        start_addr_q;
  logic [6:0]             size_q;
  logic [OFFW-1:0]        off_q;
  logic                   cross_q;
  logic [XLEN-1:0]        line_addr_q;
  logic [LW-1:0]          lo_buf_q;
  logic [PW-1:0]          pkt_data_q;

  logic                   accept;
  logic                   in_flight;
  logic                   cross_d;
  logic [SUMW-1:0]        end_sum;
  logic [2*LW-1:0]        pair;
  logic [2*LW-1:0]        shifted;
  logic [PW-1:0]          pkt_data_d;

  // Ready/valid outputs are pure decodes of state, forced low during reset
  assign o_fetch_rdy = !rst && (state_q == S_IDLE) && !drop_pend_q && !i_squash_vld;
  assign o_line_req  = !rst && ((state_q == S_REQ0) || (state_q == S_REQ1));
  assign o_pkt_vld   = !rst && (state_q == S_OUT);

  assign o_line_addr     = line_addr_q;
  assign o_pkt_ftqIdx    = ftq_idx_q;
  assign o_pkt_startAddr = start_addr_q;
  assign o_pkt_size      = size_q;
  assign o_pkt_data      = pkt_data_q;
  assign o_dbg_state     = state_q;
  assign o_dbg_drop_pend = drop_pend_q;

  assign accept  = i_fetch_req && o_fetch_rdy;
  assign end_sum = SUMW'(i_fetch_startAddr[OFFW-1:0]) + SUMW'(i_fetch_size);
  assign cross_d = end_sum > SUMW'(LINE_BYTES);

  // A request is in flight if we are waiting on it, or it is being accepted
  // right now; a response landing this same cycle means nothing is left over.
  assign in_flight = ((state_q == S_WAIT0) || (state_q == S_WAIT1) ||
                      (((state_q == S_REQ0) || (state_q == S_REQ1)) && i_line_rdy)) &&
                     !i_line_resp_vld;

  // Align the incoming line (and the buffered low line) to startAddr and clear bytes past size
  always_comb begin
    pair       = (state_q == S_WAIT1) ? {i_line_data, lo_buf_q} : {{LW{1'b0}}, i_line_data};
    shifted    = pair >> {off_q, 3'b000};
    pkt_data_d = shifted[PW-1:0];
    for (int k = 0; k < MAX_BLOCK; k++) begin
      if (k >= int'(size_q)) pkt_data_d[8*k +: 8] = 8'h00;
    end
  end

  // Block sequencer: accept, request line(s), collect data, present packet
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      drop_pend_q  <= 1'b0;
      ftq_idx_q    <= '0;
      start_addr_q <= '0;
      size_q       <= '0;
      off_q        <= '0;
      cross_q      <= 1'b0;
      line_addr_q  <= '0;
      lo_buf_q     <= '0;
      pkt_data_q   <= '0;
    end else begin
      // The stale response from a squashed block is swallowed here
      if (drop_pend_q && i_line_resp_vld) drop_pend_q <= 1'b0;

      if (i_squash_vld) begin
        state_q <= S_IDLE;
        if (in_flight) drop_pend_q <= 1'b1;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (accept) begin
              ftq_idx_q    <= i_fetch_ftqIdx;
              start_addr_q <= i_fetch_startAddr;
              size_q       <= i_fetch_size;
              off_q        <= i_fetch_startAddr[OFFW-1:0];
              cross_q      <= cross_d;
              line_addr_q  <= {i_fetch_startAddr[XLEN-1:OFFW], {OFFW{1'b0}}};
              state_q      <= S_REQ0;
            end
          end
          S_REQ0: if (i_line_rdy) state_q <= S_WAIT0;
          S_WAIT0: begin
            if (i_line_resp_vld) begin
              lo_buf_q <= i_line_data;
              if (cross_q) begin
                line_addr_q <= line_addr_q + XLEN'(LINE_BYTES);
                state_q     <= S_REQ1;
              end else begin
                pkt_data_q <= pkt_data_d;
                state_q    <= S_OUT;
              end
            end
          end
          S_REQ1: if (i_line_rdy) state_q <= S_WAIT1;
          S_WAIT1: begin
            if (i_line_resp_vld) begin
              pkt_data_q <= pkt_data_d;
              state_q    <= S_OUT;
            end
          end
          S_OUT: if (i_pkt_rdy) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  a_fetch_size: assert property (@(posedge clk) disable iff (rst)
    (i_fetch_req && o_fetch_rdy) |-> (i_fetch_size != 7'd0 && i_fetch_size <= 7'(MAX_BLOCK)));

  a_resp_expected: assert property (@(posedge clk) disable iff (rst)
    i_line_resp_vld |-> ((state_q == S_WAIT0) || (state_q == S_WAIT1) || drop_pend_q));

  a_line_aligned: assert property (@(posedge clk) disable iff (rst)
    o_line_addr[OFFW-1:0] == '0);

endmodule

// File: tb/tb_icache_fetch_ctrl.sv
// Bench for icache_fetch_ctrl: a behavioural icache responder, a block-level
// model (pending line addresses, expected packet bytes computed from byte
// addresses, count of abandoned responses) checked every cycle, and directed
// scenarios with hand-computed literal expectations.
module tb_icache_fetch_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         i_squash_vld = 1'b0;
  logic         i_fetch_req = 1'b0;
  logic         o_fetch_rdy;
  logic [4:0]   i_fetch_ftqIdx = '0;
  logic [63:0]  i_fetch_startAddr = '0;
  logic [6:0]   i_fetch_size = 7'd1;
  logic         o_line_req;
  logic [63:0]  o_line_addr;
  logic         i_line_rdy = 1'b1;
  logic         i_line_resp_vld = 1'b0;
  logic [511:0] i_line_data = '0;
  logic         o_pkt_vld;
  logic         i_pkt_rdy = 1'b1;
  logic [4:0]   o_pkt_ftqIdx;
  logic [63:0]  o_pkt_startAddr;
  logic [6:0]   o_pkt_size;
  logic [511:0] o_pkt_data;
  logic [2:0]   o_dbg_state;
  logic         o_dbg_drop_pend;

  icache_fetch_ctrl dut (
    .clk(clk), .rst(rst), .i_squash_vld(i_squash_vld),
    .i_fetch_req(i_fetch_req), .o_fetch_rdy(o_fetch_rdy),
    .i_fetch_ftqIdx(i_fetch_ftqIdx), .i_fetch_startAddr(i_fetch_startAddr),
    .i_fetch_size(i_fetch_size),
    .o_line_req(o_line_req), .o_line_addr(o_line_addr), .i_line_rdy(i_line_rdy),
    .i_line_resp_vld(i_line_resp_vld), .i_line_data(i_line_data),
    .o_pkt_vld(o_pkt_vld), .i_pkt_rdy(i_pkt_rdy), .o_pkt_ftqIdx(o_pkt_ftqIdx),
    .o_pkt_startAddr(o_pkt_startAddr), .o_pkt_size(o_pkt_size),
    .o_pkt_data(o_pkt_data), .o_dbg_state(o_dbg_state), .o_dbg_drop_pend(o_dbg_drop_pend)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters ----------------
  int vec_cnt  = 0;
  int miss_cnt = 0;
  int dut_pkt_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_wide(input string name, input logic [511:0] act, input logic [511:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vec_cnt++;
    miss_cnt++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory image ----------------
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [511:0] line_of(input logic [63:0] a);
    logic [511:0] l;
    for (int k = 0; k < 64; k++) l[8*k +: 8] = mem_byte(a + 64'(k));
    return l;
  endfunction

  function automatic logic [511:0] model_pkt(input logic [63:0] s, input int sz);
    logic [511:0] p;
    p = '0;
    for (int i = 0; i < sz; i++) p[8*i +: 8] = mem_byte(s + 64'(i));
    return p;
  endfunction

  // ---------------- icache responder ----------------
  int          gap = 1;          // cycles from request handshake to response
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic [63:0] req_log[$];

  always @(posedge clk) begin
    #1;
    if (!rst && pend_due.size() > 0 && pend_due[0] <= cyc) begin
      i_line_resp_vld = 1'b1;
      i_line_data     = line_of(pend_addr[0]);
    end else begin
      i_line_resp_vld = 1'b0;
      i_line_data     = '0;
    end
  end

  // ---------------- block-level model + scoreboard ----------------
  bit           m_active = 0;
  bit           m_outstanding = 0;
  int           m_stale = 0;
  logic [63:0]  req_q[$];
  logic [511:0] exp_q[$];
  logic [4:0]   m_idx;
  logic [63:0]  m_start;
  logic [6:0]   m_size;

  always @(negedge clk) begin
    logic exp_rdy, exp_req, exp_pkt;
    if (rst) begin
      chk("rst_fetch_rdy", 64'(o_fetch_rdy), 64'd0);
      chk("rst_line_req", 64'(o_line_req), 64'd0);
      chk("rst_pkt_vld", 64'(o_pkt_vld), 64'd0);
      m_active = 0; m_outstanding = 0; m_stale = 0;
      req_q.delete(); exp_q.delete();
      pend_addr.delete(); pend_due.delete();
    end else begin
      exp_rdy = !m_active && (m_stale == 0) && !i_squash_vld;
      exp_req = m_active && !m_outstanding && (req_q.size() > 0);
      exp_pkt = m_active && !m_outstanding && (req_q.size() == 0);
      chk("fetch_rdy", 64'(o_fetch_rdy), 64'(exp_rdy));
      chk("line_req", 64'(o_line_req), 64'(exp_req));
      chk("pkt_vld", 64'(o_pkt_vld), 64'(exp_pkt));
      chk("drop_pend", 64'(o_dbg_drop_pend), 64'(m_stale != 0));
      if (exp_req) chk("line_addr", o_line_addr, req_q[0]);
      if (exp_pkt) begin
        chk("pkt_ftqIdx", 64'(o_pkt_ftqIdx), 64'(m_idx));
        chk("pkt_startAddr", o_pkt_startAddr, m_start);
        chk("pkt_size", 64'(o_pkt_size), 64'(m_size));
        chk_wide("pkt_data", o_pkt_data, exp_q[0]);
      end

      // environment bookkeeping
      if (o_pkt_vld && i_pkt_rdy) dut_pkt_cnt++;
      if (i_line_resp_vld && pend_due.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (o_line_req && i_line_rdy) begin
        pend_addr.push_back(o_line_addr);
        pend_due.push_back(cyc + gap);
        req_log.push_back(o_line_addr);
      end

      // model update at the end of this cycle
      if (i_line_resp_vld) begin
        if (m_stale > 0) m_stale--;
        else if (m_active && m_outstanding) m_outstanding = 0;
      end
      if (exp_pkt && i_pkt_rdy) begin
        m_active = 0;
        void'(exp_q.pop_front());
      end
      if (i_squash_vld) begin
        if (m_active && (m_outstanding || (exp_req && i_line_rdy))) m_stale++;
        m_active = 0; m_outstanding = 0;
        req_q.delete(); exp_q.delete();
      end else if (exp_req && i_line_rdy) begin
        void'(req_q.pop_front());
        m_outstanding = 1;
      end
      if (exp_rdy && i_fetch_req) begin
        logic [63:0] first;
        first = {i_fetch_startAddr[63:6], 6'b0};
        req_q.delete();
        req_q.push_back(first);
        if (int'(i_fetch_startAddr[5:0]) + int'(i_fetch_size) > 64) req_q.push_back(first + 64'd64);
        exp_q.delete();
        exp_q.push_back(model_pkt(i_fetch_startAddr, int'(i_fetch_size)));
        m_idx = i_fetch_ftqIdx; m_start = i_fetch_startAddr; m_size = i_fetch_size;
        m_active = 1; m_outstanding = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [4:0] idx, input logic [63:0] addr,
                            input logic [6:0] sz, output int acc);
    i_fetch_ftqIdx = idx; i_fetch_startAddr = addr; i_fetch_size = sz;
    i_fetch_req = 1'b1;
    acc = -1;
    #1;
    for (int t = 0; t < 40; t++) begin
      if (o_fetch_rdy) begin
        acc = cyc;
        step();
        break;
      end
      step();
      #1;
    end
    i_fetch_req = 1'b0;
    if (acc < 0) fail_timeout("accept");
  endtask

  task automatic wait_pkt(input int acc, output int lat);
    lat = -1;
    for (int t = 0; t < 60; t++) begin
      if (o_pkt_vld) begin
        lat = cyc - acc;
        break;
      end
      step();
    end
    if (lat < 0) fail_timeout("pkt_wait");
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int acc, lat, base;
    repeat (3) step();
    chk("rst_line_addr", o_line_addr, 64'd0);
    chk("rst_pkt_ftqIdx", 64'(o_pkt_ftqIdx), 64'd0);
    chk("rst_pkt_startAddr", o_pkt_startAddr, 64'd0);
    chk("rst_pkt_size", 64'(o_pkt_size), 64'd0);
    chk_wide("rst_pkt_data", o_pkt_data, 512'd0);
    rst = 1'b0;
    #1;
    chk("rdy_after_rst", 64'(o_fetch_rdy), 64'd1);
    step();

    // aligned block, response three cycles after the request handshake
    gap = 3; req_log.delete();
    send_block(5'd3, 64'h8000_0000, 7'd32, acc);
    wait_pkt(acc, lat);
    chk("aligned_latency", 64'(lat), 64'd5);
    chk("aligned_idx", 64'(o_pkt_ftqIdx), 64'd3);
    chk("aligned_b0", 64'(o_pkt_data[7:0]), 64'h80);
    chk("aligned_b31", 64'(o_pkt_data[8*31 +: 8]), 64'h9F);
    chk("aligned_b32", 64'(o_pkt_data[8*32 +: 8]), 64'h00);
    step();
    chk("aligned_nreq", 64'(req_log.size()), 64'd1);
    chk("aligned_req0", req_log[0], 64'h8000_0000);

    // minimum latency
    gap = 1;
    send_block(5'd4, 64'h8000_0100, 7'd4, acc);
    wait_pkt(acc, lat);
    chk("min_latency", 64'(lat), 64'd3);
    step();

    // crossing block
    gap = 2; req_log.delete();
    send_block(5'd7, 64'h8000_0038, 7'd20, acc);
    wait_pkt(acc, lat);
    chk("cross_b0", 64'(o_pkt_data[7:0]), 64'hB8);
    chk("cross_b7", 64'(o_pkt_data[8*7 +: 8]), 64'hBF);
    chk("cross_b8", 64'(o_pkt_data[8*8 +: 8]), 64'hC0);
    chk("cross_b19", 64'(o_pkt_data[8*19 +: 8]), 64'hCB);
    chk("cross_b20", 64'(o_pkt_data[8*20 +: 8]), 64'h00);
    step();
    chk("cross_nreq", 64'(req_log.size()), 64'd2);
    chk("cross_req0", req_log[0], 64'h8000_0000);
    chk("cross_req1", req_log[1], 64'h8000_0040);

    // exact fit vs one byte over
    gap = 1; req_log.delete();
    send_block(5'd10, 64'h1000_0020, 7'd32, acc);
    wait_pkt(acc, lat);
    step();
    chk("fit_nreq", 64'(req_log.size()), 64'd1);
    req_log.delete();
    send_block(5'd11, 64'h1000_0021, 7'd64, acc);
    wait_pkt(acc, lat);
    chk("over_b63", 64'(o_pkt_data[8*63 +: 8]), 64'h70);
    step();
    chk("over_nreq", 64'(req_log.size()), 64'd2);

    // backpressure on both the line request and the packet
    req_log.delete(); base = dut_pkt_cnt;
    i_line_rdy = 1'b0;
    send_block(5'd9, 64'h5000_0010, 7'd16, acc);
    repeat (3) step();
    i_line_rdy = 1'b1; i_pkt_rdy = 1'b0;
    wait_pkt(acc, lat);
    repeat (4) step();
    i_pkt_rdy = 1'b1;
    repeat (3) step();
    chk("bp_npkt", 64'(dut_pkt_cnt - base), 64'd1);
    chk("bp_nreq", 64'(req_log.size()), 64'd1);

    // squash while waiting for the first line, response lands two cycles later
    gap = 3; base = dut_pkt_cnt;
    send_block(5'd1, 64'h2000_0000, 7'd8, acc);
    step();
    i_squash_vld = 1'b1;
    step();
    i_squash_vld = 1'b0;
    chk("sq0_drop_pend", 64'(o_dbg_drop_pend), 64'd1);
    chk("sq0_rdy_low", 64'(o_fetch_rdy), 64'd0);
    step(); step();
    chk("sq0_rdy_back", 64'(o_fetch_rdy), 64'd1);
    gap = 1;
    send_block(5'd2, 64'h3000_0040, 7'd16, acc);
    wait_pkt(acc, lat);
    chk("sq0_new_b0", 64'(o_pkt_data[7:0]), 64'h70);
    chk("sq0_new_idx", 64'(o_pkt_ftqIdx), 64'd2);
    step();
    chk("sq0_npkt", 64'(dut_pkt_cnt - base), 64'd1);

    // squash in the same cycle as the second line request handshake
    gap = 1; base = dut_pkt_cnt;
    send_block(5'd6, 64'h4000_0030, 7'd40, acc);
    lat = -1;
    for (int t = 0; t < 20; t++) begin
      if (o_line_req && o_line_addr == 64'h4000_0040) begin
        lat = t;
        break;
      end
      step();
    end
    if (lat < 0) fail_timeout("req1_wait");
    i_squash_vld = 1'b1;
    step();
    i_squash_vld = 1'b0;
    chk("sq1_drop_pend", 64'(o_dbg_drop_pend), 64'd1);
    repeat (5) step();
    chk("sq1_npkt", 64'(dut_pkt_cnt - base), 64'd0);
    chk("sq1_drop_clear", 64'(o_dbg_drop_pend), 64'd0);

    // squash together with the packet handshake still delivers the packet
    base = dut_pkt_cnt;
    send_block(5'd12, 64'h6000_0004, 7'd8, acc);
    wait_pkt(acc, lat);
    i_squash_vld = 1'b1;
    step();
    i_squash_vld = 1'b0;
    step();
    chk("sqpkt_npkt", 64'(dut_pkt_cnt - base), 64'd1);
    chk("sqpkt_rdy", 64'(o_fetch_rdy), 64'd1);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
